// File: rtl/seq_shift_pkg.sv
`default_nettype none
// ============================================================================
// seq_shift_pkg : shared types and helpers for the sequential shift unit
// Revision      : 1.0
// ============================================================================
package seq_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  // Amounts beyond the operand width saturate; the result is all zeros anyway.
  function automatic int clamp_amt(input int amt, input int n);
    return (amt > n) ? n : amt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shift_if.sv
`default_nettype none
// ============================================================================
// seq_shift_if : request/result bundle of the sequential shift unit
// Revision     : 1.0
// ============================================================================
interface seq_shift_if #(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
);
  logic          start;
  logic [N-1:0]  in;
  logic [AW-1:0] amt;
  logic [N-1:0]  out;
  logic          busy;
  logic          done;

  modport master (output start, in, amt, input out, busy, done);
  modport slave  (input start, in, amt, output out, busy, done);
endinterface
`default_nettype wire

// File: rtl/seq_shift_sll.sv
`default_nettype none
// ============================================================================
// sll : single-step combinational logical left shifter
// Revision : 1.0
// ============================================================================
module sll #(
  parameter int N     = 8,
  parameter int SHIFT = 1
) (
  input  wire logic         en_i,
  input  wire logic [N-1:0] in_i,
  output logic      [N-1:0] out_o
);

  assign out_o = en_i ? (in_i << SHIFT) : in_i;

endmodule
`default_nettype wire

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// seq_shift_unit : multi-cycle logical left shift, one bit per clock
// Revision       : 1.0
// ============================================================================
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input wire logic   clk,
  input wire logic   rst,
  seq_shift_if.slave bus
);

  shift_state_t  state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic [N-1:0]  acc_shifted;
  logic [AW-1:0] amt_clamped;

  sll #(.N(N), .SHIFT(1)) u_sll (
    .en_i  (1'b1),
    .in_i  (acc_q),
    .out_o (acc_shifted)
  );

  assign amt_clamped = AW'(clamp_amt(int'(bus.amt), N));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // out_q is only reloaded on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = bus.in;
          cnt_d = amt_clamped;
          if (amt_clamped == '0) begin
            state_d = DONE;
            out_d   = bus.in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
          out_d   = acc_shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// tb_seq_shift_unit : self-checking bench for seq_shift_unit
// Revision          : 1.0
// ============================================================================
module tb_seq_shift_unit;
  import seq_shift_pkg::*;

  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [N-1:0] prev_out;

  seq_shift_if #(.N(N), .AW(AW)) bus ();

  seq_shift_unit #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  vin;
    logic [AW-1:0] vamt;
    logic [N-1:0]  exp_out;
    int            exp_m;
    string         tag;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from plain arithmetic, not from a shift register model.
  function automatic logic [N-1:0] model(input int vin, input int vamt);
    int m;
    m = clamp_amt(vamt, N);
    return N'((vin * (1 << m)) % (1 << N));
  endfunction

  // Issues one request and checks the full busy/done/out timeline.
  task automatic run_op(input logic [N-1:0] vin, input logic [AW-1:0] vamt,
                        input logic [N-1:0] exp_out, input int exp_m, input string tag);
    bus.start = 1'b1;
    bus.in    = vin;
    bus.amt   = vamt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in    = N'($urandom);
    bus.amt   = AW'($urandom);
    for (int c = 1; c <= exp_m + 1; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
      chk({tag, "_done"}, 32'(bus.done), 32'(c == exp_m + 1));
      chk({tag, "_out"}, 32'(bus.out), 32'((c == exp_m + 1) ? exp_out : prev_out));
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done_after"}, 32'(bus.done), 32'(0));
    chk({tag, "_out_held"}, 32'(bus.out), 32'(exp_out));
    prev_out = exp_out;
  endtask

  initial begin
    int dones;
    checks    = 0;
    errors    = 0;
    prev_out  = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.amt   = '0;

    vecs[0] = '{8'h03, 4'd3,  8'h18, 3, "basic"};
    vecs[1] = '{8'hA5, 4'd0,  8'hA5, 0, "zero"};
    vecs[2] = '{8'hFF, 4'd8,  8'h00, 8, "full"};
    vecs[3] = '{8'hFF, 4'd15, 8'h00, 8, "clamp"};
    vecs[4] = '{8'h81, 4'd1,  8'h02, 1, "one"};
    vecs[5] = '{8'h5B, 4'd7,  8'h80, 7, "seven"};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(bus.out), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));

    foreach (vecs[i])
      run_op(vecs[i].vin, vecs[i].vamt, vecs[i].exp_out, vecs[i].exp_m, vecs[i].tag);

    // Second request during SHIFT must be dropped.
    bus.start = 1'b1; bus.in = 8'h01; bus.amt = 4'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.in = 8'hFF; bus.amt = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      chk("ign_done", 32'(bus.done), 32'(c == 4));
      chk("ign_busy", 32'(bus.busy), 32'(c <= 4));
      if (c >= 4) chk("ign_out", 32'(bus.out), 32'(8'h10));
      @(posedge clk); #1;
    end
    chk("ign_count", 32'(dones), 32'(1));
    prev_out = 8'h10;

    // Reset during the third SHIFT cycle aborts silently.
    bus.start = 1'b1; bus.in = 8'h77; bus.amt = 4'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rstmid_busy", 32'(bus.busy), 32'(0));
      chk("rstmid_done", 32'(bus.done), 32'(0));
      chk("rstmid_out", 32'(bus.out), 32'(0));
    end
    prev_out = '0;
    run_op(8'h01, 4'd1, 8'h02, 1, "post_rst");

    // Held start restarts every m+2 cycles.
    bus.start = 1'b1; bus.in = 8'h01; bus.amt = 4'd2;
    @(posedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("b2b_done", 32'(bus.done), 32'((c % 4) == 2));
      chk("b2b_busy", 32'(bus.busy), 32'((c % 4) != 3));
      if (bus.done) chk("b2b_out", 32'(bus.out), 32'(8'h04));
      if (c == 11) bus.start = 1'b0;
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk("b2b_idle", 32'(bus.busy), 32'(0));
    prev_out = 8'h04;

    for (int v = 0; v < 256; v++)
      for (int a = 0; a < 10; a++)
        run_op(N'(v), AW'(a), model(v, a), clamp_amt(a, N), "sweep");

    for (int k = 0; k < 40; k++) begin
      int v;
      int a;
      v = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, 15));
      run_op(N'(v), AW'(a), model(v, a), clamp_amt(a, N), "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
